// File: rtl/race_round_controller.sv
// race_round_controller
// Round and score sequencer for the Red Light, Green Light racer game.
// Racer 0 is the human player and the remaining racers are AI. A game is
// N_ROUNDS rounds. In each round a racer is disqualified for moving on red,
// and the lowest-index qualified racer to reach FINISH_X scores one point.
// At the end of the game the champion (and whether it is tied) is reported.
//
// Ports:
//   clk               system clock
//   reset             synchronous, active-high reset
//   start_key         active-low start button (a falling edge is a press)
//   red_light         1 while the red light is shown
//   moved             per-racer movement request this cycle
//   pos_x             packed racer x positions, racer i at [i*X_W +: X_W]
//   game_active       high in RESET_POS or PLAYING
//   scores            packed per-racer score counters
//   round_num         current round, 1..N_ROUNDS
//   winner_valid      the round just ended had a winner
//   winner_id         index of the last round winner
//   dq                per-racer disqualified flag for the current round
//   blink             per-racer blink (1 = draw hidden)
//   show_start_screen high in START
//   show_final_scores high in GAME_OVER
//   champion_id       highest-score racer (lowest index on ties)
//   champion_tie      more than one racer holds the top score
module race_round_controller #(
    parameter int N_RACERS     = 4,
    parameter int X_W          = 10,
    parameter int FINISH_X     = 580,
    parameter int N_ROUNDS     = 3,
    parameter int SCORE_W      = 4,
    parameter int RESET_DELAY  = 2500000,
    parameter int ROUND_DELAY  = 100000000,
    parameter int BLINK_HALF   = 12500000,
    parameter int BLINK_PHASES = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_key,
    input  logic                        red_light,
    input  logic [N_RACERS-1:0]         moved,
    input  logic [N_RACERS*X_W-1:0]     pos_x,
    output logic                        game_active,
    output logic [N_RACERS*SCORE_W-1:0] scores,
    output logic [2:0]                  round_num,
    output logic                        winner_valid,
    output logic [2:0]                  winner_id,
    output logic [N_RACERS-1:0]         dq,
    output logic [N_RACERS-1:0]         blink,
    output logic                        show_start_screen,
    output logic                        show_final_scores,
    output logic [2:0]                  champion_id,
    output logic                        champion_tie
);

    localparam int CNT_W = 32;

    typedef enum logic [2:0] {
        ST_START      = 3'd0,
        ST_IDLE       = 3'd1,
        ST_RESET_POS  = 3'd2,
        ST_PLAYING    = 3'd3,
        ST_ROUND_END  = 3'd4,
        ST_NEXT_ROUND = 3'd5,
        ST_GAME_OVER  = 3'd6
    } state_t;

    state_t                      state_r, state_next_s;
    logic                        key_q_r;
    logic                        press_s;
    logic [CNT_W-1:0]            cnt_r;
    logic [N_RACERS*SCORE_W-1:0] scores_r;
    logic [2:0]                  round_num_r;
    logic                        winner_valid_r;
    logic [2:0]                  winner_id_r;
    logic [N_RACERS-1:0]         dq_r, dq_next_s, qual_s;
    logic [2:0]                  win_idx_s;
    logic [SCORE_W-1:0]          score_sel_s, score_inc_s;
    logic                        win_s, no_win_s;
    logic                        game_active_r, show_start_r, show_final_r;
    logic [N_RACERS-1:0]         blink_r, run_r;
    logic [CNT_W-1:0]            half_r  [N_RACERS];
    logic [CNT_W-1:0]            phase_r [N_RACERS];
    logic [SCORE_W-1:0]          best_s;
    logic [2:0]                  champ_s;
    logic                        tie_s;

    // A press is the cycle the key goes from released (1) to pressed (0).
    assign press_s = key_q_r & ~start_key;

    assign game_active       = game_active_r;
    assign scores            = scores_r;
    assign round_num         = round_num_r;
    assign winner_valid      = winner_valid_r;
    assign winner_id         = winner_id_r;
    assign dq                = dq_r;
    assign blink             = blink_r;
    assign show_start_screen = show_start_r;
    assign show_final_scores = show_final_r;
    assign champion_id       = champ_s;
    assign champion_tie      = tie_s;

    // Disqualification update and lowest-index qualifier search.
    always_comb begin
        dq_next_s = dq_r | (moved & {N_RACERS{red_light}});
        qual_s    = '0;
        win_idx_s = 3'd0;
        // Walk downwards so the lowest qualifying index is the one kept.
        for (int i = N_RACERS - 1; i >= 0; i--) begin
            if ((pos_x[i*X_W +: X_W] >= X_W'(FINISH_X)) && !dq_next_s[i]) begin
                qual_s[i] = 1'b1;
                win_idx_s = 3'(i);
            end else begin
                qual_s[i] = 1'b0;
            end
        end
        score_sel_s = scores_r[win_idx_s*SCORE_W +: SCORE_W];
        if (score_sel_s == {SCORE_W{1'b1}}) begin
            score_inc_s = score_sel_s;
        end else begin
            score_inc_s = score_sel_s + SCORE_W'(1);
        end
    end

    // Champion search over the score table (lowest index wins ties).
    always_comb begin
        best_s  = scores_r[0 +: SCORE_W];
        champ_s = 3'd0;
        tie_s   = 1'b0;
        for (int i = 1; i < N_RACERS; i++) begin
            if (scores_r[i*SCORE_W +: SCORE_W] > best_s) begin
                best_s  = scores_r[i*SCORE_W +: SCORE_W];
                champ_s = 3'(i);
            end else begin
                best_s  = best_s;
            end
        end
        for (int i = 0; i < N_RACERS; i++) begin
            if ((scores_r[i*SCORE_W +: SCORE_W] == best_s) && (3'(i) != champ_s)) begin
                tie_s = 1'b1;
            end else begin
                tie_s = tie_s;
            end
        end
    end

    // Next-state logic and round outcome strobes.
    always_comb begin
        state_next_s = state_r;
        win_s        = 1'b0;
        no_win_s     = 1'b0;
        case (state_r)
            ST_START: begin
                if (press_s) state_next_s = ST_IDLE;
                else         state_next_s = state_r;
            end
            ST_IDLE: begin
                if (press_s) state_next_s = ST_RESET_POS;
                else         state_next_s = state_r;
            end
            ST_RESET_POS: begin
                if (cnt_r == CNT_W'(RESET_DELAY - 1)) state_next_s = ST_PLAYING;
                else                                  state_next_s = state_r;
            end
            ST_PLAYING: begin
                if (|qual_s) begin
                    state_next_s = ST_ROUND_END;
                    win_s        = 1'b1;
                end else if (&dq_next_s) begin
                    state_next_s = ST_ROUND_END;
                    no_win_s     = 1'b1;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_ROUND_END: begin
                if (cnt_r == CNT_W'(ROUND_DELAY - 1)) begin
                    if (round_num_r == 3'(N_ROUNDS)) state_next_s = ST_GAME_OVER;
                    else                             state_next_s = ST_NEXT_ROUND;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_NEXT_ROUND: state_next_s = ST_IDLE;
            ST_GAME_OVER:  state_next_s = state_r;
            default:       state_next_s = ST_START;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= ST_START;
        else       state_r <= state_next_s;
    end

    // Dwell counter, restarted from 0 on every state change.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (state_next_s != state_r) begin
            cnt_r <= '0;
        end else if ((state_r == ST_RESET_POS) || (state_r == ST_ROUND_END)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= '0;
        end
    end

    // Scores, round tracking, disqualification and registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_q_r        <= 1'b1;
            scores_r       <= '0;
            round_num_r    <= 3'd1;
            winner_valid_r <= 1'b0;
            winner_id_r    <= 3'd0;
            dq_r           <= '0;
            game_active_r  <= 1'b0;
            show_start_r   <= 1'b1;
            show_final_r   <= 1'b0;
        end else begin
            key_q_r       <= start_key;
            game_active_r <= (state_next_s == ST_RESET_POS) || (state_next_s == ST_PLAYING);
            show_start_r  <= (state_next_s == ST_START);
            show_final_r  <= (state_next_s == ST_GAME_OVER);
            case (state_r)
                ST_IDLE: begin
                    dq_r           <= '0;
                    winner_valid_r <= 1'b0;
                end
                ST_PLAYING: begin
                    dq_r <= dq_next_s;
                    if (win_s) begin
                        scores_r[win_idx_s*SCORE_W +: SCORE_W] <= score_inc_s;
                        winner_id_r    <= win_idx_s;
                        winner_valid_r <= 1'b1;
                    end else if (no_win_s) begin
                        winner_valid_r <= 1'b0;
                    end
                end
                ST_NEXT_ROUND: round_num_r <= round_num_r + 3'd1;
                default: ;
            endcase
        end
    end

    // Per-racer blink timers: BLINK_PHASES phases of BLINK_HALF cycles, odd phases hidden.
    always_ff @(posedge clk) begin
        if (reset || (state_r == ST_IDLE)) begin
            run_r   <= '0;
            blink_r <= '0;
            for (int i = 0; i < N_RACERS; i++) begin
                half_r[i]  <= '0;
                phase_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_RACERS; i++) begin
                if ((state_r == ST_PLAYING) && dq_next_s[i] && !dq_r[i]) begin
                    run_r[i]   <= 1'b1;
                    blink_r[i] <= 1'b0;
                    half_r[i]  <= '0;
                    phase_r[i] <= '0;
                end else if (run_r[i]) begin
                    if (half_r[i] == CNT_W'(BLINK_HALF - 1)) begin
                        half_r[i] <= '0;
                        if (phase_r[i] == CNT_W'(BLINK_PHASES - 1)) begin
                            run_r[i]   <= 1'b0;
                            blink_r[i] <= 1'b0;
                            phase_r[i] <= '0;
                        end else begin
                            // The next phase is odd exactly when the current one is even.
                            blink_r[i] <= ~phase_r[i][0];
                            phase_r[i] <= phase_r[i] + CNT_W'(1);
                        end
                    end else begin
                        half_r[i] <= half_r[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule
